hazard_fwd_unit: RTL
====================

# hazard_fwd_unit

Parametrised hazard and forwarding controller for the pipelined MIPS core; the successor to the two-operand forwarding unit. Resolves RAW hazards for `NUM_SRC` source operands by forwarding from EX/MEM or MEM/WB. Inserts load-use bubbles through a counted stall FSM. Freezes the whole pipeline while data memory is not ready, with a timeout error.

## Interface
- `REG_AW`, 5: register address width
- `NUM_SRC`, 2: source operands per instruction (Rs, Rt, …)
- `LOAD_USE_CYC`, 1: bubbles inserted per load-use hazard (≥1)
- `WAIT_TIMEOUT`, 64: MEM_WAIT cycles before `mem_timeout_err`
- `CNT_W`, 16: perf counter width
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `ifid_src`  in  NUM_SRC*REG_AW  source addresses of the instruction in ID; operand k at [k*REG_AW +: REG_AW]
- `ifid_src_used`  in  NUM_SRC  operand k actually read
- `idex_src`  in  NUM_SRC*REG_AW  source addresses of the instruction in EX
- `idex_rd`  in  REG_AW  destination register in EX
- `idex_memread`  in  1  instruction in EX is a load
- `exmem_rd`  in  REG_AW  destination register in MEM
- `exmem_regwrite`  in  1  MEM-stage instruction writes a register
- `exmem_memreq`  in  1  MEM-stage instruction accesses memory
- `memwb_rd`  in  REG_AW  destination register in WB
- `memwb_regwrite`  in  1  WB-stage instruction writes a register
- `mem_ready`  in  1  data memory completes the access this cycle
- `fwd_sel`  out  NUM_SRC*2  per-operand select: 00 register file, 01 EX/MEM, 10 MEM/WB
- `stall_if`  out  1  hold PC
- `stall_id`  out  1  hold IF/ID
- `flush_ex`  out  1  load a bubble into ID/EX
- `freeze`  out  1  hold all pipeline registers (memory wait)
- `mem_timeout_err`  out  1  sticky timeout flag

## Operation
- Forwarding is combinational for each operand k.
  - EX/MEM is selected when `exmem_regwrite`, `exmem_rd`≠0 and `exmem_rd`==src k.
  - Otherwise MEM/WB is selected when `memwb_regwrite`, `memwb_rd`≠0 and `memwb_rd`==src k.
  - Otherwise the register file is selected. EX/MEM has priority.
  - `fwd_sel` is all 00 while `rst` is high.
- A load-use hazard exists when `idex_memread`, `idex_rd`≠0, and `idex_rd` equals a used `ifid_src`.
- The FSM has three states: RUN, LOAD_STALL and MEM_WAIT.
- RUN:
  - If `exmem_memreq`&&!`mem_ready`, go to MEM_WAIT.
  - Else on a load-use hazard, assert `stall_if`/`stall_id`/`flush_ex` this cycle. If `LOAD_USE_CYC`>1, load the counter with `LOAD_USE_CYC`-1 and go to LOAD_STALL.
- LOAD_STALL:
  - Assert `stall_if`/`stall_id`/`flush_ex` and decrement the counter.
  - Return to RUN when the counter reaches 0.
  - If a memory wait starts, go to MEM_WAIT; the counter is kept and resumed afterwards.
- MEM_WAIT:
  - Assert `freeze` only (`stall_*`/`flush_ex` = 0). The timeout counter increments each cycle.
  - On `mem_ready`, go to LOAD_STALL if the saved bubble count is >0, else to RUN. Clear the timeout counter.
  - When the counter reaches `WAIT_TIMEOUT`, set `mem_timeout_err`. It stays set until `rst`. The FSM stays in MEM_WAIT.
- Simultaneous memory wait and load-use hazard: the memory wait wins. The hazard is re-evaluated after the freeze, because the inputs are held.

## Timing
- Reset values (registered): state=RUN; bubble and timeout counters 0; `stall_if`/`stall_id`/`flush_ex`/`freeze`/`mem_timeout_err` = 0.
- `rst` asserted mid-operation forces RUN on the next edge and discards pending bubbles.
- Load-use hazard detected in cycle N gives exactly `LOAD_USE_CYC` consecutive cycles of stall/flush starting at N, with no memory wait.
- `freeze` rises in the same cycle `exmem_memreq`&&!`mem_ready` is seen. It falls in the cycle `mem_ready` is sampled high.
- `mem_timeout_err` rises `WAIT_TIMEOUT` cycles after MEM_WAIT entry.
- Forwarding has zero latency, with no state dependence.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - Adds outputs `stall_cnt` and `freeze_cnt` (CNT_W each).
  - `stall_cnt` counts cycles with `stall_id` high; `freeze_cnt` counts cycles with `freeze` high.
  - Both saturate at all-ones and clear on `rst`.
- Undefined: the ports and the counters are absent.

## Structure
- Package `hazard_pkg` holds:
  - the state enum (RUN, LOAD_STALL, MEM_WAIT);
  - the fwd_sel constants FWD_REG=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
- Sub-module `hazard_src_match` covers one operand: the comparators, the zero-register check and the priority encode. It is generated `NUM_SRC` times.

## Test plan
- `exmem_rd`=`memwb_rd`=5, both regwrite, `idex_src`[0]=5 -> `fwd_sel`[1:0]=01. Repeat with `exmem_regwrite`=0 -> 10.
- `exmem_rd`=0 with regwrite, src=0 -> `fwd_sel`=00 for every operand.
- `LOAD_USE_CYC`=2: `idex_memread`, `idex_rd`=8, `ifid_src`[1]=8 used -> `stall_if`/`stall_id`/`flush_ex` high for exactly 2 cycles. The same match with `ifid_src_used`[1]=0 -> no stall.
- `exmem_memreq`=1, `mem_ready`=0 for 3 cycles, then 1 -> `freeze` high for 3 cycles, `mem_timeout_err` stays 0.
- `WAIT_TIMEOUT`=4, `mem_ready` held 0 -> `mem_timeout_err` rises after 4 cycles and remains high; `rst` pulse -> all outputs 0, state RUN.
- Load-use hazard with a memory wait starting in the same cycle -> `freeze` first, then the full bubble count after `mem_ready`. With `HAZARD_PERF_CNT_EN`, check `stall_cnt`/`freeze_cnt` against the counted cycles.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard / forwarding controller.
package hazard_pkg;

    // Stall controller states.
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } hazard_state_e;

    // Per-operand forwarding mux select.
    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

endpackage

// File: rtl/hazard_src_match.sv
// One source operand: forwarding priority select for the EX-stage operand,
// and load-use match for the ID-stage operand in the same slot.
module hazard_src_match
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] ex_src,
    input  logic [REG_AW-1:0] id_src,
    input  logic              id_src_used,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic              idex_memread,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_regwrite,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_regwrite,
    output logic [1:0]        sel,
    output logic              load_use
);

    logic exmem_hit;
    logic memwb_hit;

    // Register 0 is hardwired to zero, so a write to it never forwards.
    assign exmem_hit = exmem_regwrite && (exmem_rd != '0) && (exmem_rd == ex_src);
    assign memwb_hit = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == ex_src);

    assign load_use  = idex_memread && id_src_used &&
                       (idex_rd != '0) && (idex_rd == id_src);

    // Priority encode: the younger EX/MEM result wins over MEM/WB.
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves sel
        // unassigned; otherwise synthesis infers a latch.
        sel = FWD_REG;
        if (exmem_hit) begin
            sel = FWD_EXMEM;
        end else if (memwb_hit) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding controller for the pipelined MIPS core.
// Forwarding is purely combinational; load-use bubbles and memory-wait
// freezes come from a three-state controller (RUN / LOAD_STALL / MEM_WAIT).
// Optional feature: define HAZARD_PERF_CNT_EN to add the saturating
// stall_cnt / freeze_cnt performance counters.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int NUM_SRC      = 2,
    parameter int LOAD_USE_CYC = 1,
    parameter int WAIT_TIMEOUT = 64,
    parameter int CNT_W        = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*REG_AW-1:0] ifid_src,
    input  logic [NUM_SRC-1:0]        ifid_src_used,
    input  logic [NUM_SRC*REG_AW-1:0] idex_src,
    input  logic [REG_AW-1:0]         idex_rd,
    input  logic                      idex_memread,
    input  logic [REG_AW-1:0]         exmem_rd,
    input  logic                      exmem_regwrite,
    input  logic                      exmem_memreq,
    input  logic [REG_AW-1:0]         memwb_rd,
    input  logic                      memwb_regwrite,
    input  logic                      mem_ready,
    output logic [NUM_SRC*2-1:0]      fwd_sel,
    output logic                      stall_if,
    output logic                      stall_id,
    output logic                      flush_ex,
    output logic                      freeze,
    output logic                      mem_timeout_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          freeze_cnt
`endif
);

    // Bubble counter holds LOAD_USE_CYC-1 at most; timeout counter up to WAIT_TIMEOUT.
    localparam int BUB_W = (LOAD_USE_CYC > 1) ? $clog2(LOAD_USE_CYC) : 1;
    localparam int TMO_W = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [BUB_W-1:0] BUB_INIT = BUB_W'(LOAD_USE_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(WAIT_TIMEOUT);

    logic [NUM_SRC*2-1:0] fwd_raw;
    logic [NUM_SRC-1:0]   lu_hit;
    logic                 load_use;
    logic                 mem_wait_req;

    hazard_state_e    state_q, state_d;
    logic [BUB_W-1:0] bub_q, bub_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_set;
    logic             stall;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        hazard_src_match #(
            .REG_AW (REG_AW)
        ) u_match (
            .ex_src         (idex_src[k*REG_AW +: REG_AW]),
            .id_src         (ifid_src[k*REG_AW +: REG_AW]),
            .id_src_used    (ifid_src_used[k]),
            .idex_rd        (idex_rd),
            .idex_memread   (idex_memread),
            .exmem_rd       (exmem_rd),
            .exmem_regwrite (exmem_regwrite),
            .memwb_rd       (memwb_rd),
            .memwb_regwrite (memwb_regwrite),
            .sel            (fwd_raw[k*2 +: 2]),
            .load_use       (lu_hit[k])
        );
    end

    assign load_use     = |lu_hit;
    assign mem_wait_req = exmem_memreq && !mem_ready;
    assign fwd_sel      = rst ? '0 : fwd_raw;

    // State register with synchronous reset; pending bubbles are discarded.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= RUN;
            bub_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bub_q   <= bub_d;
            tmo_q   <= tmo_d;
            err_q   <= err_q | err_set;
        end
    end

    // Next-state logic: a memory wait always takes precedence over bubbles.
    always_comb begin
        state_d = state_q;
        bub_d   = bub_q;
        tmo_d   = tmo_q;
        err_set = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_wait_req) begin
                    state_d = MEM_WAIT;
                end else if (load_use && (LOAD_USE_CYC > 1)) begin
                    bub_d   = BUB_INIT;
                    state_d = LOAD_STALL;
                end
            end
            LOAD_STALL: begin
                // Remaining bubble count is kept across a memory wait.
                if (mem_wait_req) begin
                    state_d = MEM_WAIT;
                end else begin
                    bub_d = bub_q - 1'b1;
                    if (bub_q == BUB_W'(1)) begin
                        state_d = RUN;
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    tmo_d   = '0;
                    state_d = (bub_q != '0) ? LOAD_STALL : RUN;
                end else if (tmo_q != TMO_MAX) begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_q == TMO_MAX - 1'b1) begin
                        err_set = 1'b1;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Output decode: stall/flush and freeze are mutually exclusive, all low in reset.
    always_comb begin
        stall  = 1'b0;
        freeze = 1'b0;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (mem_wait_req) begin
                        freeze = 1'b1;
                    end else if (load_use) begin
                        stall = 1'b1;
                    end
                end
                LOAD_STALL: begin
                    if (mem_wait_req) begin
                        freeze = 1'b1;
                    end else begin
                        stall = 1'b1;
                    end
                end
                MEM_WAIT: freeze = !mem_ready;
                default: ;
            endcase
        end
    end

    assign stall_if        = stall;
    assign stall_id        = stall;
    assign flush_ex        = stall;
    assign mem_timeout_err = err_q;

`ifdef HAZARD_PERF_CNT_EN
    // Saturating cycle counters for stall_id and freeze.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            freeze_cnt <= '0;
        end else begin
            if (stall_id && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (freeze && (freeze_cnt != '1)) begin
                freeze_cnt <= freeze_cnt + 1'b1;
            end
        end
    end
`else
    // Counter width has no meaning without the perf counters.
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule
